// File: rtl/step_spawn_scheduler_if.sv
// Handshake/bus bundle between the song/pattern logic and the spawn scheduler.
// master : pattern side, drives START/STOP/SONG_LEN/REQ and watches the beat outputs.
// slave  : scheduler side, consumes the controls and drives GRANT/BEAT/PHASE/BUSY/DONE.
//   START     1  sync pulse, begin or restart a song
//   STOP      1  sync pulse, abort the song
//   SONG_LEN  8  beats in the song, sampled when START is accepted
//   REQ       4  lane spawn requests, bit0=LEFT .. bit3=RIGHT
//   GRANT     4  one-hot spawn grant, coincident with BEAT
//   BEAT      1  one-cycle pulse per beat boundary
//   PHASE     3  beat number mod 8
//   BUSY      1  song running
//   DONE      1  one-cycle pulse with the final beat
interface step_spawn_scheduler_if;
    logic       START;
    logic       STOP;
    logic [7:0] SONG_LEN;
    logic [3:0] REQ;
    logic [3:0] GRANT;
    logic       BEAT;
    logic [2:0] PHASE;
    logic       BUSY;
    logic       DONE;

    modport master (
        output START, STOP, SONG_LEN, REQ,
        input  GRANT, BEAT, PHASE, BUSY, DONE
    );

    modport slave (
        input  START, STOP, SONG_LEN, REQ,
        output GRANT, BEAT, PHASE, BUSY, DONE
    );
endinterface

// File: rtl/step_spawn_scheduler.sv
// Beat sequencer and round-robin arrow-spawn arbiter for the DDR game core.
// Divides CLOCK into TICK_DIV-cycle beat slots, advances a 3-bit beat phase,
// grants at most one lane spawn request per eligible beat and ends the song
// after the latched number of beats.
// Ports:
//   CLOCK  system clock, rising edge
//   RESET  asynchronous active-low reset
//   bus    slave side of step_spawn_scheduler_if (controls in, beat/grant out)
module step_spawn_scheduler #(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned GAP_MIN  = 1
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    step_spawn_scheduler_if.slave  bus
);

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LANES   = 4;
    localparam int unsigned RR_W    = 2;
    localparam int unsigned GAP_W   = 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_NEED = GAP_W'(GAP_MIN - 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q,    state_d;
    logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   song_len_q, song_len_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic [RR_W-1:0]    rr_q,       rr_d;
    // Beats since the last grant, saturating; large value means "eligible".
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic [LANES-1:0]   grant_q,    grant_d;
    logic               beat_q,     beat_d;
    logic               done_q,     done_d;
    logic               busy_q,     busy_d;

    logic [RR_W-1:0]    win_c;
    logic               any_req_c;
    logic               start_ok_c;
    logic               terminal_c;

    // Round-robin search from rr: walk lanes from farthest to nearest so the
    // nearest requesting lane (ascending mod 4) is the last one written.
    always_comb begin
        logic [RR_W-1:0] idx;
        win_c     = rr_q;
        any_req_c = 1'b0;
        idx       = rr_q;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = rr_q + RR_W'(k);
            if (bus.REQ[idx]) begin
                win_c     = idx;
                any_req_c = 1'b1;
            end
        end
    end

    assign start_ok_c = bus.START && !bus.STOP && (bus.SONG_LEN != '0);
    assign terminal_c = (div_cnt_q == DIV_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        beat_cnt_d = beat_cnt_q;
        song_len_d = song_len_q;
        phase_d    = phase_q;
        rr_d       = rr_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        grant_d    = '0;
        beat_d     = 1'b0;
        done_d     = 1'b0;

        if ((state_q == S_RUN) && bus.STOP) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            div_cnt_d = '0;
            phase_d   = '0;
        end else if (start_ok_c) begin
            // Fresh song from IDLE, or restart while running.
            state_d    = S_RUN;
            busy_d     = 1'b1;
            div_cnt_d  = '0;
            phase_d    = '0;
            beat_cnt_d = '0;
            rr_d       = '0;
            gap_cnt_d  = GAP_SAT;
            song_len_d = bus.SONG_LEN;
        end else if (state_q == S_RUN) begin
            if (terminal_c) begin
                div_cnt_d  = '0;
                beat_d     = 1'b1;
                phase_d    = phase_q + PHASE_W'(1);
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if ((gap_cnt_q >= GAP_NEED) && any_req_c) begin
                    grant_d   = LANES'(1) << win_c;
                    rr_d      = win_c + RR_W'(1);
                    gap_cnt_d = '0;
                end else if (gap_cnt_q != GAP_SAT) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
                // Final beat leaves RUN on the same edge it is issued.
                if (beat_cnt_d == song_len_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            beat_cnt_q <= '0;
            song_len_q <= '0;
            phase_q    <= '0;
            rr_q       <= '0;
            gap_cnt_q  <= '0;
            grant_q    <= '0;
            beat_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            song_len_q <= song_len_d;
            phase_q    <= phase_d;
            rr_q       <= rr_d;
            gap_cnt_q  <= gap_cnt_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.GRANT = grant_q;
    assign bus.BEAT  = beat_q;
    assign bus.PHASE = phase_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

endmodule
